// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 2-flop input synchroniser,
// mid-bit sampling, optional parity, 1 or 2 stop bits and a valid/ready
// output register.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote
// of the samples at CLKS_PER_BIT/2-1, /2 and /2+1. Without it, the single
// sample at CLKS_PER_BIT/2 is used. Bit decisions are taken at count /2+1 in
// both builds, so frame timing does not depend on the option.
//
// Output handshake: out/rxValid form a valid/ready source. A word is
// transferred on every rising edge where rxValid & rxReady are both 1, and
// rxValid drops on the following cycle unless a new frame completes on that
// same edge, in which case the new word replaces the consumed one and rxValid
// stays 1. A frame completing while rxValid = 1 and rxReady = 0 is dropped and
// flagged with rxOverrun.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 870,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxEnable,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out,
    output logic                 rxValid,
    input  logic                 rxReady,
    output logic                 rxDone,
    output logic                 rxError,
    output logic                 parityError,
    output logic                 frameError,
    output logic                 rxOverrun,
    output logic                 rxBusy,
    output logic [2:0]           dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] EARLY = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DEC   = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_sync_d;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 s_early;
    logic                 s_mid;
    logic                 par_err;
    logic                 frm_err;

    logic start_edge;
    logic at_dec;
    logic bit_val;
    logic par_exp;
    logic last_data;
    logic last_stop;
    logic frame_end;

    // A start is a high-to-low transition of the synchronised line, so a line
    // held low (break) never re-triggers until it has returned high.
    assign start_edge = rx_sync_d & ~rx_sync & rxEnable;
    assign at_dec     = (cnt == DEC);
    assign last_data  = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop  = (bit_cnt == 4'(STOP_BITS - 1));
    assign par_exp    = (^shift) ^ (PARITY == 1);

`ifdef UART_RX_MAJORITY_EN
    assign bit_val = (s_early & s_mid) | (s_early & rx_sync) | (s_mid & rx_sync);
`else
    assign bit_val = s_mid;
`endif

    assign rxBusy    = (state != S_IDLE);
    assign dbg_state = state;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; frame_end marks the last stop-bit decision.
    always_comb begin
        next_state = state;
        frame_end  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge) next_state = S_START;
            end
            S_START: begin
                if (at_dec) next_state = bit_val ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (at_dec && last_data) next_state = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (at_dec) next_state = S_STOP;
            end
            S_STOP: begin
                if (at_dec && last_stop) begin
                    next_state = S_IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (!rxEnable) begin
            next_state = S_IDLE;
            frame_end  = 1'b0;
        end
    end

    // Synchroniser, bit timing, shift register, error flags and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_sync_d   <= 1'b1;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            s_early     <= 1'b1;
            s_mid       <= 1'b1;
            par_err     <= 1'b0;
            frm_err     <= 1'b0;
            out         <= '0;
            rxValid     <= 1'b0;
            rxDone      <= 1'b0;
            rxError     <= 1'b0;
            parityError <= 1'b0;
            frameError  <= 1'b0;
            rxOverrun   <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_sync     <= rx_meta;
            rx_sync_d   <= rx_sync;
            rxDone      <= 1'b0;
            rxError     <= 1'b0;
            parityError <= 1'b0;
            frameError  <= 1'b0;
            rxOverrun   <= 1'b0;

            // The falling-edge cycle counts as tick 0 of the start bit, so the
            // counter already lines up with bit boundaries from here on.
            if (state == S_IDLE) begin
                cnt <= start_edge ? CW'(1) : '0;
            end else if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (cnt == EARLY) s_early <= rx_sync;
            if (cnt == HALF)  s_mid   <= rx_sync;

            if (start_edge && state == S_IDLE) begin
                bit_cnt <= '0;
                par_err <= 1'b0;
                frm_err <= 1'b0;
            end

            if (at_dec) begin
                case (state)
                    S_DATA: begin
                        shift   <= {bit_val, shift[DATA_BITS-1:1]};
                        bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
                    end
                    S_PARITY: par_err <= (bit_val != par_exp);
                    S_STOP: begin
                        frm_err <= frm_err | ~bit_val;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end

            if (frame_end) begin
                rxDone      <= 1'b1;
                parityError <= par_err;
                frameError  <= frm_err | ~bit_val;
                rxError     <= par_err | frm_err | ~bit_val;
                if (!rxValid || rxReady) begin
                    out     <= shift;
                    rxValid <= 1'b1;
                end else begin
                    rxOverrun <= 1'b1;
                end
            end else if (rxValid && rxReady) begin
                rxValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E2 instance share
// clock, reset and rxEnable. Follows UART_RX_MAJORITY_EN for the glitch case.
module tb_uart_rx_param;

    localparam int CLKS = 32;
    localparam int HALF = CLKS / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_en;
    logic       rx;
    logic       rx_ready;
    logic [7:0] out;
    logic       valid, done, err, perr, ferr, ovr, busy;
    logic [2:0] dbg;

    logic       rx_p;
    logic       rx_ready_p;
    logic [7:0] out_p;
    logic       valid_p, done_p, err_p, perr_p, ferr_p, ovr_p, busy_p;
    logic [2:0] dbg_p;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int done_p_cnt = 0;
    bit busy_seen = 0;

    logic [7:0] c_out, cp_out;
    logic c_err, c_perr, c_ferr, c_ovr, c_busy;
    logic cp_err, cp_perr, cp_ferr;
    logic [7:0] exp_q[$];
    logic [7:0] exp6;
    int d0;

    uart_rx_param #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .rxEnable(rx_en), .rx(rx), .out(out), .rxValid(valid),
        .rxReady(rx_ready), .rxDone(done), .rxError(err), .parityError(perr),
        .frameError(ferr), .rxOverrun(ovr), .rxBusy(busy), .dbg_state(dbg)
    );

    uart_rx_param #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_p (
        .clk(clk), .rst(rst), .rxEnable(rx_en), .rx(rx_p), .out(out_p), .rxValid(valid_p),
        .rxReady(rx_ready_p), .rxDone(done_p), .rxError(err_p), .parityError(perr_p),
        .frameError(ferr_p), .rxOverrun(ovr_p), .rxBusy(busy_p), .dbg_state(dbg_p)
    );

    // clock
    always #10 clk = ~clk;

    // watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (done) begin
            done_cnt++;
            c_out = out; c_err = err; c_perr = perr; c_ferr = ferr;
            c_ovr = ovr; c_busy = busy;
            if (exp_q.size() == 0) check("sb_spurious_done", done, 1'b0);
            else check("sb_out", out, exp_q.pop_front());
        end
        if (done_p) begin
            done_p_cnt++;
            cp_out = out_p; cp_err = err_p; cp_perr = perr_p; cp_ferr = ferr_p;
        end
    end

    task automatic set_line(input bit to_p, input logic v);
        if (to_p) rx_p = v;
        else rx = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one bit period; optional 1-clk low glitch at the sample point and an
    // rxReady pulse aligned with the final stop-bit decision
    task automatic drive_bit(input logic v, input bit to_p, input bit glitch, input bit mark);
        set_line(to_p, v);
        for (int j = 1; j <= CLKS; j++) begin
            @(posedge clk);
            #1;
            if (glitch && j == HALF)     set_line(to_p, 1'b0);
            if (glitch && j == HALF + 1) set_line(to_p, v);
            if (mark && j == HALF + 3)   rx_ready = 1'b1;
            if (mark && j == HALF + 4)   rx_ready = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input int par, input int nstop,
                              input logic stop_val, input bit to_p, input int glitch_bit,
                              input bit mark);
        drive_bit(1'b0, to_p, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i], to_p, i == glitch_bit, 1'b0);
        if (par >= 0) drive_bit(par[0], to_p, 1'b0, 1'b0);
        for (int s = 0; s < nstop; s++)
            drive_bit((s == nstop - 1) ? stop_val : 1'b1, to_p, 1'b0, mark && (s == nstop - 1));
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rx_p = 1'b1; rx_en = 1'b1; rx_ready = 1'b0; rx_ready_p = 1'b1;
        idle(5);
        rst = 1'b0;
        idle(3);
        check("rst_out", out, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_state", dbg, 3'd0);

        // 8N1 0x8B, held until consumed
        exp_q.push_back(8'h8B);
        d0 = done_cnt;
        send_frame(8'h8B, -1, 1, 1'b1, 1'b0, -1, 1'b0);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_out", c_out, 8'h8B);
        check("t1_err", c_err, 1'b0);
        check("t1_ferr", c_ferr, 1'b0);
        check("t1_busy_at_done", c_busy, 1'b0);
        idle(5);
        check("t1_valid_held", valid, 1'b1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check("t1_consumed", valid, 1'b0);
        rx_ready = 1'b1;

        // even parity, 2 stop bits
        d0 = done_p_cnt;
        send_frame(8'h8F, 0, 2, 1'b1, 1'b1, -1, 1'b0);
        check("t2_done_cnt", done_p_cnt - d0, 1);
        check("t2_perr", cp_perr, 1'b1);
        check("t2_err", cp_err, 1'b1);
        check("t2_ferr", cp_ferr, 1'b0);
        check("t2_out", cp_out, 8'h8F);
        send_frame(8'h8F, 1, 2, 1'b1, 1'b1, -1, 1'b0);
        check("t2_good_perr", cp_perr, 1'b0);
        check("t2_good_err", cp_err, 1'b0);
        send_frame(8'h3A, 0, 2, 1'b0, 1'b1, -1, 1'b0);
        check("t2_stop2_ferr", cp_ferr, 1'b1);
        check("t2_stop2_perr", cp_perr, 1'b0);
        check("t2_stop2_out", cp_out, 8'h3A);
        check("t2_total", done_p_cnt - d0, 3);
        rx_p = 1'b1;

        // stop bit 0 followed by a break
        exp_q.push_back(8'h55);
        d0 = done_cnt;
        send_frame(8'h55, -1, 1, 1'b0, 1'b0, -1, 1'b0);
        check("t3_ferr", c_ferr, 1'b1);
        check("t3_err", c_err, 1'b1);
        check("t3_perr", c_perr, 1'b0);
        check("t3_out", c_out, 8'h55);
        d0 = done_cnt;
        busy_seen = 1'b0;
        idle(20 * CLKS);
        check("t3_break_done", done_cnt - d0, 0);
        check("t3_break_busy", busy_seen, 1'b0);
        rx = 1'b1;
        idle(2 * CLKS);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, -1, 1, 1'b1, 1'b0, -1, 1'b0);
        check("t3_recover_cnt", done_cnt - d0, 1);
        check("t3_recover_ferr", c_ferr, 1'b0);

        // short low pulse: false start
        busy_seen = 1'b0;
        d0 = done_cnt;
        rx = 1'b0;
        idle(HALF - 4);
        rx = 1'b1;
        idle(2 * CLKS);
        check("t4_busy_seen", busy_seen, 1'b1);
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_idle", dbg, 3'd0);

        // reset during data bit 4
        rx_ready = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, -1, 1, 1'b1, 1'b0, -1, 1'b0);
        check("t4_pre_valid", valid, 1'b1);
        drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        idle(HALF);
        check("t4_busy_mid", busy, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rx = 1'b1;
        check("t4_rst_out", out, 8'h00);
        check("t4_rst_valid", valid, 1'b0);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_state", dbg, 3'd0);
        d0 = done_cnt;
        idle(12 * CLKS);
        check("t4_rst_no_done", done_cnt - d0, 0);

        // overrun with rxReady low
        exp_q.push_back(8'h11);
        d0 = done_cnt;
        send_frame(8'h11, -1, 1, 1'b1, 1'b0, -1, 1'b0);
        check("t5_first_ovr", c_ovr, 1'b0);
        check("t5_first_out", c_out, 8'h11);
        exp_q.push_back(8'h11);
        send_frame(8'h22, -1, 1, 1'b1, 1'b0, -1, 1'b0);
        check("t5_done_cnt", done_cnt - d0, 2);
        check("t5_ovr", c_ovr, 1'b1);
        check("t5_out_kept", out, 8'h11);
        check("t5_valid_kept", valid, 1'b1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check("t5_consumed", valid, 1'b0);

        // consume on the same edge as a new frame completes
        exp_q.push_back(8'h44);
        send_frame(8'h44, -1, 1, 1'b1, 1'b0, -1, 1'b0);
        exp_q.push_back(8'h66);
        send_frame(8'h66, -1, 1, 1'b1, 1'b0, -1, 1'b1);
        check("t5_sim_ovr", c_ovr, 1'b0);
        check("t5_sim_out", out, 8'h66);
        check("t5_sim_valid", valid, 1'b1);
        rx_ready = 1'b1;

        // glitch at the sample point of data bit 3
`ifdef UART_RX_MAJORITY_EN
        exp6 = 8'hFF;
`else
        exp6 = 8'hF7;
`endif
        exp_q.push_back(exp6);
        send_frame(8'hFF, -1, 1, 1'b1, 1'b0, 3, 1'b0);
        check("t6_out", c_out, exp6);
        check("t6_ferr", c_ferr, 1'b0);

        // rxEnable dropped mid-frame
        d0 = done_cnt;
        drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
        check("t7_busy_before", busy, 1'b1);
        rx_en = 1'b0;
        idle(1);
        check("t7_abort_state", dbg, 3'd0);
        check("t7_abort_busy", busy, 1'b0);
        rx = 1'b1;
        idle(12 * CLKS);
        check("t7_no_done", done_cnt - d0, 0);
        check("t7_out_kept", out, exp6);
        rx_en = 1'b1;
        idle(2);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, -1, 1, 1'b1, 1'b0, -1, 1'b0);
        check("t7_recover_out", c_out, 8'hA5);
        check("t7_recover_cnt", done_cnt - d0, 1);

        idle(4);
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
